// File: rtl/tiger_defines.sv
// Shared store-path definitions: store size codes and byte-lane constants.
// Latency: none; constants and types only.
// Backpressure: n/a. Lane order is big-endian: offset 0 maps to byteenable[3].
package tiger_defines;

  // Store size codes carried by req_size
  localparam logic [2:0] SIZE_SB  = 3'd0;
  localparam logic [2:0] SIZE_SH  = 3'd1;
  localparam logic [2:0] SIZE_SW  = 3'd2;
  localparam logic [2:0] SIZE_SWL = 3'd3;
  localparam logic [2:0] SIZE_SWR = 3'd4;

  // Byte-lane enables (big-endian: offset 0 is the MSB lane)
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam logic [3:0] BE_LANE0   = 4'b1000;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;

  // One aligned store beat: lane-positioned data and its enables
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
  } lane_t;

endpackage

// File: rtl/tiger_store_align.sv
// Store alignment: places store data on big-endian byte lanes, makes enables, flags faults.
// Latency: purely combinational.
// Backpressure: none. SWL/SWR decode only when TIGER_STORE_PARTIAL_EN is defined.
module tiger_store_align
  import tiger_defines::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  size,
  input  logic [31:0] data,
  output logic [31:0] lane_data,
  output logic [3:0]  byteenable,
  output logic        fault
);

  // Decode size/offset into lane data, enables and misalignment/illegal fault
  always_comb begin
    lane_data  = 32'h0;
    byteenable = BE_NONE;
    fault      = 1'b0;
    case (size)
      SIZE_SB: begin
        lane_data  = {4{data[7:0]}};
        byteenable = BE_LANE0 >> addr;
      end
      SIZE_SH: begin
        lane_data  = {2{data[15:0]}};
        byteenable = addr[1] ? BE_HALF_LO : BE_HALF_HI;
        fault      = addr[0];
      end
      SIZE_SW: begin
        lane_data  = data;
        byteenable = BE_ALL;
        fault      = (addr != 2'b00);
      end
`ifdef TIGER_STORE_PARTIAL_EN
      // Store-word-left: high-order bytes of rt go from the addressed byte to the word end
      SIZE_SWL: begin
        case (addr)
          2'd0: begin lane_data = data;                  byteenable = 4'b1111; end
          2'd1: begin lane_data = {8'h0,  data[31:8]};   byteenable = 4'b0111; end
          2'd2: begin lane_data = {16'h0, data[31:16]};  byteenable = 4'b0011; end
          default: begin lane_data = {24'h0, data[31:24]}; byteenable = 4'b0001; end
        endcase
      end
      // Store-word-right: low-order bytes of rt go from the word start to the addressed byte
      SIZE_SWR: begin
        case (addr)
          2'd0: begin lane_data = {data[7:0],  24'h0};   byteenable = 4'b1000; end
          2'd1: begin lane_data = {data[15:0], 16'h0};   byteenable = 4'b1100; end
          2'd2: begin lane_data = {data[23:0], 8'h0};    byteenable = 4'b1110; end
          default: begin lane_data = data;               byteenable = 4'b1111; end
        endcase
      end
`endif
      default: begin
        fault = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/tiger_store_unit.sv
// In-order store buffer: aligns MA-stage stores and drains them over an Avalon-style master.
// Latency: request accepted at edge N drives avm_write in cycle N+1 at the earliest.
// Backpressure: stall_out while full (held request ignored); avm_waitrequest holds the head.
// Optional SWL/SWR support via TIGER_STORE_PARTIAL_EN.
module tiger_store_unit
  import tiger_defines::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [2:0]        req_size,
  output logic              stall_out,
  output logic              busy,
  output logic              store_fault,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  lane_t             lane_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [31:0] align_data;
  logic [3:0]  align_be;
  logic        align_fault;

  tiger_store_align u_align (
    .addr       (req_addr[1:0]),
    .size       (req_size),
    .data       (req_data),
    .lane_data  (align_data),
    .byteenable (align_be),
    .fault      (align_fault)
  );

  // Occupancy flags come from the registered count so stall_out has no input path
  always_comb begin
    full  = (count == CNT_W'(DEPTH));
    empty = (count == '0);
    push  = req_valid && !full && !align_fault;
    pop   = !empty && !avm_waitrequest;
  end

  // Entry storage: written at the tail; only read while non-empty, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= {req_addr[ADDR_W-1:2], 2'b00};
      lane_mem[wr_ptr] <= '{data: align_data, be: align_be};
    end
  end

  // Pointers and count; a full buffer refuses a push even when the head pops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Fault pulse: one cycle after any faulting request, even while full; it is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      store_fault <= 1'b0;
    end else begin
      store_fault <= req_valid && align_fault;
    end
  end

  // Master port mirrors the head entry; gated to zero while empty and during reset
  always_comb begin
    stall_out      = full;
    busy           = !empty;
    avm_write      = !empty;
    avm_address    = '0;
    avm_writedata  = 32'h0;
    avm_byteenable = BE_NONE;
    if (!empty) begin
      avm_address    = addr_mem[rd_ptr];
      avm_writedata  = lane_mem[rd_ptr].data;
      avm_byteenable = lane_mem[rd_ptr].be;
    end
  end

endmodule

// File: tb/tb_tiger_store_unit.sv
// Directed bench for tiger_store_unit with a write scoreboard on the master port.
// Latency: checks at negedge; inputs change 1ns after posedge.
// Backpressure: drives avm_waitrequest and honours stall_out on held requests.
module tb_tiger_store_unit;
  import tiger_defines::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [2:0]  req_size;
  logic        stall_out;
  logic        busy;
  logic        store_fault;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  fails    = 0;
  int  pops     = 0;
  int  expected = 0;

  always #5 clk = ~clk;

  tiger_store_unit #(.DEPTH(2), .ADDR_W(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .req_size        (req_size),
    .stall_out       (stall_out),
    .busy            (busy),
    .store_fault     (store_fault),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.addr = a; e.data = d; e.be = be;
    exp_q.push_back(e);
    expected++;
  endtask

  // Present a request from posedge+1; it is taken at the next edge; returns at posedge+1
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Scoreboard: every completed write must match the oldest expected entry
  always @(negedge clk) begin
    if (reset_n && avm_write && !avm_waitrequest) begin
      wr_t e;
      pops++;
      checks++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL sb_unexpected: observed write %h expected none", avm_address);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_addr", avm_address, e.addr);
        chk("sb_data", avm_writedata, e.data);
        chk("sb_be", {28'h0, avm_byteenable}, {28'h0, e.be});
      end
    end
  end

  initial begin
    logic s;
    logic acc;
    int   p0;
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
    req_size = SIZE_SW; avm_waitrequest = 1'b0;

    // Reset state
    #2;
    chk("rst_write", {31'h0, avm_write}, 32'h0);
    chk("rst_addr", avm_address, 32'h0);
    chk("rst_data", avm_writedata, 32'h0);
    chk("rst_be", {28'h0, avm_byteenable}, 32'h0);
    chk("rst_stall", {31'h0, stall_out}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_fault", {31'h0, store_fault}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // SB at offset 3, no wait states
    expect_wr(32'h1000, 32'hABABABAB, 4'b0001);
    issue(32'h1003, 32'h000000AB, SIZE_SB);
    @(negedge clk);
    chk("sb_write", {31'h0, avm_write}, 32'h1);
    chk("sb_addr_d", avm_address, 32'h1000);
    chk("sb_data_d", avm_writedata, 32'hABABABAB);
    chk("sb_be_d", {28'h0, avm_byteenable}, 32'h1);
    chk("sb_busy", {31'h0, busy}, 32'h1);
    chk("sb_nofault", {31'h0, store_fault}, 32'h0);
    @(negedge clk);
    chk("sb_busy_fall", {31'h0, busy}, 32'h0);

    // SB at offset 0 lands on the MSB lane
    @(posedge clk); #1;
    expect_wr(32'h1100, 32'h78787878, 4'b1000);
    issue(32'h1100, 32'h12345678, SIZE_SB);
    @(negedge clk);
    @(negedge clk);

    // SH at offset 2 with three wait states: head held stable, single pop
    @(posedge clk); #1;
    avm_waitrequest = 1'b1;
    p0 = pops;
    expect_wr(32'h2000, 32'h12341234, 4'b0011);
    issue(32'h2002, 32'h00001234, SIZE_SH);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sh_write", {31'h0, avm_write}, 32'h1);
      chk("sh_addr", avm_address, 32'h2000);
      chk("sh_data", avm_writedata, 32'h12341234);
      chk("sh_be", {28'h0, avm_byteenable}, 32'h3);
    end
    @(posedge clk); #1;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    chk("sh_addr4", avm_address, 32'h2000);
    @(negedge clk);
    chk("sh_busy", {31'h0, busy}, 32'h0);
    chk("sh_single_pop", pops, p0 + 1);

    // Three SW into a 2-deep buffer behind waitrequest: third held until space frees
    @(posedge clk); #1;
    avm_waitrequest = 1'b1;
    expect_wr(32'h3000, 32'hA0A0A0A0, 4'b1111);
    expect_wr(32'h3004, 32'hB1B1B1B1, 4'b1111);
    expect_wr(32'h3008, 32'hC2C2C2C2, 4'b1111);
    issue(32'h3000, 32'hA0A0A0A0, SIZE_SW);
    chk("full_stall_one", {31'h0, stall_out}, 32'h0);
    issue(32'h3004, 32'hB1B1B1B1, SIZE_SW);
    req_valid = 1'b1; req_addr = 32'h3008; req_data = 32'hC2C2C2C2; req_size = SIZE_SW;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_stall", {31'h0, stall_out}, 32'h1);
      chk("full_head", avm_address, 32'h3000);
      @(posedge clk); #1;
    end
    avm_waitrequest = 1'b0;
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      s = stall_out;
      @(posedge clk); #1;
      if (!s) begin
        acc = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    chk("full_third_accepted", {31'h0, acc}, 32'h1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("full_drained", {31'h0, busy}, 32'h0);

    // Misaligned SW faults for one cycle and enqueues nothing
    @(posedge clk); #1;
    issue(32'h4001, 32'h11223344, SIZE_SW);
    @(negedge clk);
    chk("mis_fault", {31'h0, store_fault}, 32'h1);
    chk("mis_write", {31'h0, avm_write}, 32'h0);
    chk("mis_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("mis_fault_pulse", {31'h0, store_fault}, 32'h0);

    // Illegal size code
    @(posedge clk); #1;
    issue(32'h4100, 32'h0, 3'd6);
    @(negedge clk);
    chk("ill_fault", {31'h0, store_fault}, 32'h1);
    chk("ill_busy", {31'h0, busy}, 32'h0);

    // SWL at offset 2 (and SWR at offset 1 when enabled)
    @(posedge clk); #1;
`ifdef TIGER_STORE_PARTIAL_EN
    expect_wr(32'h5000, 32'h0000DEAD, 4'b0011);
    issue(32'h5002, 32'hDEADBEEF, SIZE_SWL);
    @(negedge clk);
    chk("swl_fault", {31'h0, store_fault}, 32'h0);
    chk("swl_data", avm_writedata, 32'h0000DEAD);
    chk("swl_be", {28'h0, avm_byteenable}, 32'h3);
    @(posedge clk); #1;
    expect_wr(32'h5100, 32'hBEEF0000, 4'b1100);
    issue(32'h5101, 32'hDEADBEEF, SIZE_SWR);
    @(negedge clk);
    chk("swr_be", {28'h0, avm_byteenable}, 32'hC);
    @(negedge clk);
`else
    issue(32'h5002, 32'hDEADBEEF, SIZE_SWL);
    @(negedge clk);
    chk("swl_fault", {31'h0, store_fault}, 32'h1);
    chk("swl_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    issue(32'h5101, 32'hDEADBEEF, SIZE_SWR);
    @(negedge clk);
    chk("swr_fault", {31'h0, store_fault}, 32'h1);
    chk("swr_busy", {31'h0, busy}, 32'h0);
`endif

    // Reset mid-transfer aborts the write; a following SW issues normally
    @(posedge clk); #1;
    avm_waitrequest = 1'b1;
    issue(32'h6000, 32'h66666666, SIZE_SW);
    @(negedge clk);
    chk("abort_write_pre", {31'h0, avm_write}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_write", {31'h0, avm_write}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_addr", avm_address, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    avm_waitrequest = 1'b0;
    expect_wr(32'h7000, 32'h77777777, 4'b1111);
    issue(32'h7000, 32'h77777777, SIZE_SW);
    @(negedge clk);
    chk("post_rst_write", {31'h0, avm_write}, 32'h1);
    chk("post_rst_addr", avm_address, 32'h7000);
    @(negedge clk);
    chk("post_rst_busy", {31'h0, busy}, 32'h0);

    chk("sb_empty", exp_q.size(), 32'h0);
    chk("sb_pop_total", pops, expected);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/tiger_store_unit.md
Name: tiger_store_unit

Overview:
- Write-side counterpart of the memory-access stage load path: accepts store requests from the MA stage, aligns data to byte lanes, generates byte enables and drains them to data memory over an Avalon-style master port.
- Small in-order store buffer decouples pipeline from memory wait states; back-pressures the pipeline when full.
- Big-endian lane ordering: address offset 0 maps to writedata[31:24] / byteenable[3].

Parameters:
DEPTH, 2, store buffer entries; power of 2, range 2..8
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  qualified store in MA stage (upstream already gated by stall/clear)
req_addr  in  ADDR_W  byte address from execute stage
req_data  in  32  rt register value
req_size  in  3  0=SB 1=SH 2=SW 3=SWL 4=SWR; 5..7 illegal
stall_out  out  1  buffer full; upstream must hold request
busy  out  1  buffer non-empty; loads must not issue while high
store_fault  out  1  one-cycle pulse on misaligned or illegal store
avm_address  out  ADDR_W  word-aligned address (bits [1:0]=0)
avm_write  out  1  write strobe
avm_writedata  out  32  lane-aligned data
avm_byteenable  out  4  lane enables
avm_waitrequest  in  1  slave not ready

Behaviour:
- Reset (async, reset_n low): pointers and count cleared; avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0, store_fault=0, stall_out=0, busy=0. avm_write drops immediately even mid-transfer; aborted write is acceptable.
- Push: req_valid && !full at a rising edge -> entry {aligned addr, lane data, byteenable} written at tail.
- req_valid while full: ignored; upstream holds the request via stall_out.
- Full blocks push even if a pop occurs in the same cycle; stall_out = full, decoded from registered count.
- Drain: avm_write = !empty. Head drives avm_address/writedata/byteenable, held stable while avm_waitrequest=1.
- Pop: avm_write && !avm_waitrequest.
- Push and pop in the same cycle (not full): both occur; count unchanged.
- Latency: request accepted at edge N -> avm_write high in cycle N+1 at earliest.
- Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1 to distinguish full from empty.
- busy = !empty.
- Alignment rules:
  - SB: data {4{d[7:0]}}, be 4'b1000 >> addr[1:0].
  - SH: data {2{d[15:0]}}, be addr[1] ? 0011 : 1100; addr[0]=1 is a fault.
  - SW: data d, be 1111; addr[1:0]!=0 is a fault.
- Fault: request not enqueued; store_fault registered high for exactly one cycle after the accepting edge. A faulting request while full still pulses store_fault and is not held.

Optional Feature:
- Macro TIGER_STORE_PARTIAL_EN enables SWL/SWR (codes 3 and 4).
- SWL, by offset:
  - 0: d, 1111
  - 1: {8'h0,d[31:8]}, 0111
  - 2: {16'h0,d[31:16]}, 0011
  - 3: {24'h0,d[31:24]}, 0001
- SWR, by offset:
  - 0: {d[7:0],24'h0}, 1000
  - 1: {d[15:0],16'h0}, 1100
  - 2: {d[23:0],8'h0}, 1110
  - 3: d, 1111
- SWL/SWR never fault.
- Without the macro: codes 3 and 4 are illegal, so store_fault pulses and nothing is enqueued.

Decomposition:
- Store size codes (SIZE_SB..SIZE_SWR) and lane constants go in the shared tiger_defines file.
- One combinational sub-module, tiger_store_align: inputs addr[1:0], size, data; outputs lane data, byteenable, fault. It is reused by the cache write path.
- FIFO storage and pointers stay inline in tiger_store_unit.

Test Plan:
- SB addr 0x1003 data 0x000000AB, waitrequest=0 -> next cycle avm_address 0x1000, writedata 0xABABABAB, byteenable 0001, busy falls one cycle later.
- SH addr 0x2002 data 0x1234, waitrequest=1 for 3 cycles -> outputs stable 0x2000/0x12341234/0011 for 4 cycles, single pop.
- DEPTH=2, three back-to-back SW with waitrequest=1 -> stall_out high after two pushes, third held; waitrequest released -> all three written in order.
- SW addr 0x4001 -> store_fault single pulse, avm_write stays 0, busy stays 0.
- SWL addr 0x5002 data 0xDEADBEEF with TIGER_STORE_PARTIAL_EN -> writedata 0x0000DEAD, byteenable 0011; without macro -> store_fault pulse.
- reset_n low while avm_write=1 and waitrequest=1 -> avm_write 0 immediately, busy 0, subsequent SW issues normally.
